// File: rtl/seq10010_pkg.sv
// Shared types and constants for the "10010" serial sequence detectors.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq10010_pkg;

    // Pattern watched for, oldest bit in the MSB.
    localparam logic [4:0] PATTERN = 5'b10010;

    // Mealy detector: each state names the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        M0 = 3'd0,  // no prefix
        M1 = 3'd1,  // "1"
        M2 = 3'd2,  // "10"
        M3 = 3'd3,  // "100"
        M4 = 3'd4   // "1001"
    } mealy_state_e;

    // Moore detector: same prefixes as the Mealy machine plus a "matched" state
    // so the detect flag can be decoded from registered state alone.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // no prefix
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "100"
        S4 = 3'd4,  // "1001"
        S5 = 3'd5   // "10010" matched
    } moore_state_e;

endpackage

// File: rtl/moore_10010_q.sv
// Moore-style "10010" detector: moore is high for the cycle following the final bit.
// Latency: one clock after the edge that samples the last pattern bit.
// Backpressure: none; one bit is consumed every clock.
module moore_10010_q
    import seq10010_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic moore
);

    moore_state_e state_q;
    moore_state_e state_d;

    // State register; rst low clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any encoding outside S0..S5 falls back to S0.
    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0: state_d = j ? S1 : S0;
            S1: state_d = j ? S1 : S2;
            S2: state_d = j ? S1 : S3;
            S3: state_d = j ? S4 : S0;
            S4: state_d = j ? S1 : S5;
            // After a hit the trailing "10" is already a valid prefix, so
            // a following 0 continues straight into "100" when overlapping.
            S5: state_d = j ? S1 : (OVERLAP ? S3 : S0);
            default: state_d = S0;
        endcase
    end

    // Output decoded from registered state only, so j glitches never reach it.
    always_comb begin
        moore = (state_q == S5);
    end

endmodule

// File: rtl/mealy_10010_q.sv
// Serial "10010" detector with a combinational Mealy flag and a registered Moore flag.
// Latency: mealy in the cycle the final 0 is presented; moore one clock later.
// Backpressure: none; one bit is consumed every clock.
module mealy_10010_q
    import seq10010_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic mealy,
    output logic moore
);

    mealy_state_e state_q;
    mealy_state_e state_d;

    // State register; rst low clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= M0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Mealy output; unknown encodings recover to M0 with mealy low.
    always_comb begin
        state_d = M0;
        mealy   = 1'b0;
        unique case (state_q)
            M0: state_d = j ? M1 : M0;
            M1: state_d = j ? M1 : M2;
            M2: state_d = j ? M1 : M3;
            M3: state_d = j ? M4 : M0;
            M4: begin
                // The last pattern bit completes the match right now.
                mealy   = (j == PATTERN[0]);
                // When overlapping, the "10" just seen is reused as a new prefix.
                state_d = j ? M1 : (OVERLAP ? M2 : M0);
            end
            default: begin
                state_d = M0;
                mealy   = 1'b0;
            end
        endcase
    end

    // Moore detector runs on the same stream and reset as the Mealy machine.
    moore_10010_q #(
        .OVERLAP (OVERLAP)
    ) u_moore (
        .clk   (clk),
        .rst   (rst),
        .j     (j),
        .moore (moore)
    );

endmodule

// File: tb/tb_mealy_10010_q.sv
module tb_mealy_10010_q;

    localparam logic [4:0] PAT = 5'b10010;

    logic clk = 1'b0;
    logic rst;
    logic j;
    logic mealy_ov, moore_ov;
    logic mealy_no, moore_no;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits seen since reset (overlap) and since reset or last hit (non-overlap).
    bit hist_ov[$];
    bit hist_no[$];

    int hits_mealy_ov, hits_moore_ov, hits_mealy_no, hits_moore_no;
    logic pre_mealy_ov, pre_mealy_no;

    always #10 clk = ~clk;

    mealy_10010_q #(.OVERLAP(1'b1)) u_ov (
        .clk   (clk),
        .rst   (rst),
        .j     (j),
        .mealy (mealy_ov),
        .moore (moore_ov)
    );

    mealy_10010_q #(.OVERLAP(1'b0)) u_no (
        .clk   (clk),
        .rst   (rst),
        .j     (j),
        .mealy (mealy_no),
        .moore (moore_no)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mealy_ov"}, mealy_ov, 1'b0);
        check({tag, "_moore_ov"}, moore_ov, 1'b0);
        check({tag, "_mealy_no"}, mealy_no, 1'b0);
        check({tag, "_moore_no"}, moore_no, 1'b0);
    endtask

    // Would presenting bit b complete the pattern, given the model history?
    function automatic bit would_hit(input bit ov, input bit b);
        int n;
        logic [4:0] w;
        n = ov ? hist_ov.size() : hist_no.size();
        if (n < 4) return 1'b0;
        w = 5'b0;
        for (int k = 0; k < 4; k++) begin
            w[4-k] = ov ? hist_ov[n-4+k] : hist_no[n-4+k];
        end
        w[0] = b;
        return (w == PAT);
    endfunction

    task automatic model_clear();
        hist_ov.delete();
        hist_no.delete();
    endtask

    task automatic clear_counts();
        hits_mealy_ov = 0;
        hits_moore_ov = 0;
        hits_mealy_no = 0;
        hits_moore_no = 0;
    endtask

    // Called just after a rising edge: pulse reset across one edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_clear();
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst = 1'b1;
    endtask

    // Called just after a rising edge: present b, check mealy, clock it, check moore.
    task automatic drive_bit(input bit b);
        bit e_ov, e_no;
        j = b;
        #4;
        e_ov = would_hit(1'b1, b);
        e_no = would_hit(1'b0, b);
        check("mealy_ov", mealy_ov, e_ov);
        check("mealy_no", mealy_no, e_no);
        pre_mealy_ov = mealy_ov;
        pre_mealy_no = mealy_no;
        hits_mealy_ov += int'(mealy_ov);
        hits_mealy_no += int'(mealy_no);
        @(posedge clk);
        #1;
        hist_ov.push_back(b);
        if (hist_ov.size() > 8) void'(hist_ov.pop_front());
        hist_no.push_back(b);
        if (e_no) hist_no.delete();
        check("moore_ov", moore_ov, e_ov);
        check("moore_no", moore_no, e_no);
        check("diff_ov", moore_ov ^ pre_mealy_ov, 1'b0);
        check("diff_no", moore_no ^ pre_mealy_no, 1'b0);
        hits_moore_ov += int'(moore_ov);
        hits_moore_no += int'(moore_no);
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            drive_bit(bits[i]);
        end
    endtask

    task automatic check_counts(input string tag, input int ov, input int no);
        check_int({tag, "_hits_mealy_ov"}, hits_mealy_ov, ov);
        check_int({tag, "_hits_moore_ov"}, hits_moore_ov, ov);
        check_int({tag, "_hits_mealy_no"}, hits_mealy_no, no);
        check_int({tag, "_hits_moore_no"}, hits_moore_no, no);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        j   = 1'b0;
        clear_counts();
        pre_mealy_ov = 1'b0;
        pre_mealy_no = 1'b0;

        // Reset held with j toggling: outputs stay low.
        #3;
        check_all_zero("reset_hold");
        for (int i = 0; i < 6; i++) begin
            #7 j = ~j;
            #1;
            check_all_zero("reset_toggle");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();

        // Quiet bits after release: nothing fires.
        drive_bit(1'b0);
        drive_bit(1'b0);

        // Single pattern.
        clear_counts();
        drive_seq(16'b10010, 5);
        check_counts("single", 1, 1);

        // Overlapping tail: two hits with overlap, one without.
        do_reset();
        clear_counts();
        drive_seq(16'b10010010, 8);
        check_counts("overlap", 2, 1);

        // Reset in the middle of a pattern while the final 0 is already presented.
        do_reset();
        clear_counts();
        drive_seq(16'b1001, 4);
        j = 1'b0;
        #4;
        check("pre_reset_mealy_ov", mealy_ov, would_hit(1'b1, 1'b0));
        check("pre_reset_mealy_no", mealy_no, would_hit(1'b0, 1'b0));
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_counts();
        drive_bit(1'b0);
        check_counts("after_mid_rst", 0, 0);

        // Near-miss stream with one hit at the end.
        do_reset();
        clear_counts();
        drive_seq(16'b1100110010, 10);
        check_counts("near_miss", 1, 1);

        // Random stream with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            drive_bit(1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mealy_10010_q.md
MEALY_10010_Q -- requirements
Module: mealy_10010_q

Interface
REQ-001 Parameter: OVERLAP, default 1, 1 = overlapping detection of "10010", 0 = non-overlapping (matcher restarts from empty after a hit).
REQ-002 Ports: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Ports: rst  input  1  reset, asynchronous, active-low.
REQ-004 Ports: j  input  1  serial data bit, sampled on rising clk.
REQ-005 Ports: mealy  output  1  Mealy-style detect flag, combinational from state and j.
REQ-006 Ports: moore  output  1  Moore-style detect flag, decoded from registered state only.

Function
REQ-007 Both detectors SHALL watch the serial stream, MSB-first in time, for the pattern 1,0,0,1,0.
REQ-008 Mealy FSM SHALL use states M0 (no prefix), M1 ("1"), M2 ("10"), M3 ("100") and M4 ("1001").
REQ-009 Mealy transitions on j=0/j=1: M0 -> M0/M1; M1 -> M2/M1; M2 -> M3/M1; M3 -> M0/M4; M4 -> (OVERLAP ? M2 : M0)/M1.
REQ-010 mealy SHALL be 1 exactly when state is M4 and j=0; it asserts in the same cycle as the final 0 is presented, before the capturing edge; otherwise 0.
REQ-011 Moore FSM SHALL use states S0..S4 with the same meaning as M0..M4, plus S5 ("10010 matched").
REQ-012 Moore transitions on j=0/j=1: S0 -> S0/S1; S1 -> S2/S1; S2 -> S3/S1; S3 -> S0/S4; S4 -> S5/S1; S5 -> (OVERLAP ? S3 : S0)/S1.
REQ-013 moore SHALL be 1 exactly while state is S5: one full clock cycle, starting at the edge that samples the final 0. This is one cycle later than mealy.
REQ-014 With OVERLAP=1, the suffix "10" of a hit SHALL count as a new prefix: "10010010" yields two hits, at bit 5 and bit 8.
REQ-015 With OVERLAP=0, "10010010" SHALL yield one hit only (bit 5).
REQ-016 Consecutive hits SHALL be at least 3 bits apart (overlap). The outputs SHALL never assert for any partial pattern.
REQ-017 Unreachable state encodings SHALL return to M0/S0 on the next edge with both outputs 0.
REQ-018 Glitches on j between edges may appear on mealy. moore SHALL be glitch-free with respect to j.

Reset
REQ-019 rst=0 SHALL immediately (asynchronously) force both FSMs to M0/S0, independent of clk.
REQ-020 During reset, moore=0 and mealy=0 regardless of j.
REQ-021 Release (rst 0->1) SHALL take effect at the first rising edge after release. A pattern in progress before reset SHALL be forgotten.

Structure
REQ-022 A shared package (seq10010_pkg) SHALL hold the state enums for both FSMs and the pattern constant 5'b10010.
REQ-023 The Moore detector SHALL be a sub-module, moore_10010_q (ports clk, rst, j, moore), instantiated once inside mealy_10010_q. The Mealy FSM SHALL be coded directly in the top.
REQ-024 Each FSM SHALL use a two-process style (state register plus next-state/output logic) with binary encoding.

Verification
REQ-025 Bench clock period 20 ns. Hold rst=0 with j toggling -> mealy=moore=0 throughout. Release rst -> outputs stay 0 until a full match.
REQ-026 After reset, drive j=1,0,0,1,0 (one bit per cycle) -> mealy=1 while the 5th bit (0) is applied; moore=1 for the one cycle after that edge; both 0 otherwise.
REQ-027 With OVERLAP=1, drive 1,0,0,1,0,0,1,0 -> mealy pulses on bits 5 and 8; moore pulses one cycle after each.
REQ-028 With OVERLAP=0, drive the same 1,0,0,1,0,0,1,0 -> a single pulse on each output (bit 5 only).
REQ-029 Drive 1,0,0,1 then assert rst mid-cycle, release, drive 0 -> no assertion. Outputs go 0 immediately on rst fall.
REQ-030 Drive 1,1,0,0,1,1,0,0,1,0 -> exactly one hit, at the final bit. Continuously check diff = mealy XOR (moore delayed back one cycle) == 0.
